// File: rtl/axi_rd_burst_ctrl_if.sv
// AXI4 read address/data channel bundle for axi_rd_burst_ctrl.
// The slave modport is the controller side; the master modport drives requests.
interface axi_rd_burst_ctrl_if #(
  parameter int AW  = 32,
  parameter int DW  = 32,
  parameter int IDW = 4
);
  logic           i_arvalid;
  logic           o_arready;
  logic [AW-1:0]  i_araddr;
  logic [IDW-1:0] i_arid;
  logic [7:0]     i_arlen;
  logic [2:0]     i_arsize;
  logic [1:0]     i_arburst;
  logic           o_rvalid;
  logic           i_rready;
  logic [DW-1:0]  o_rdata;
  logic [IDW-1:0] o_rid;
  logic [1:0]     o_rresp;
  logic           o_rlast;

  modport slave (
    input  i_arvalid, i_araddr, i_arid, i_arlen, i_arsize, i_arburst, i_rready,
    output o_arready, o_rvalid, o_rdata, o_rid, o_rresp, o_rlast
  );

  modport master (
    output i_arvalid, i_araddr, i_arid, i_arlen, i_arsize, i_arburst, i_rready,
    input  o_arready, o_rvalid, o_rdata, o_rid, o_rresp, o_rlast
  );
endinterface

// File: rtl/axi_rd_burst_ctrl.sv
// AXI4 read-channel slave: walks FIXED/INCR/WRAP bursts into a 1-cycle SRAM via a 2-entry R buffer.
// Optional macro AXI_RD_ERR_EN enables DECERR/SLVERR responses for out-of-range beats or oversized bursts.
module axi_rd_burst_ctrl #(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int IDW       = 4,
  parameter int MEM_BYTES = 4096
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  axi_rd_burst_ctrl_if.slave    s_axi,
  output logic                  o_mem_rd_en,
  output logic [AW-1:0]         o_mem_addr,
  input  logic [DW-1:0]         i_mem_rdata,
  output logic                  o_busy
);

  localparam int DSZ = $clog2(DW / 8);
`ifdef AXI_RD_ERR_EN
  localparam bit LP_ERR_EN = 1'b1;
`else
  localparam bit LP_ERR_EN = 1'b0;
`endif

  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DRAIN} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_arready;
  logic                w_arready_nxt;

  logic [AW-1:0]       r_addr;
  logic [IDW-1:0]      r_id;
  logic [7:0]          r_len;
  logic [2:0]          r_size;
  logic [1:0]          r_burst;
  logic [8:0]          r_issued;

  logic                r_inflight;
  logic                r_if_last;
  logic                r_if_err;
  logic [1:0]          r_if_resp;

  logic [1:0][DW-1:0]  r_buf_data;
  logic [1:0][1:0]     r_buf_resp;
  logic [1:0]          r_buf_last;
  logic                r_wr_ptr;
  logic                r_rd_ptr;
  logic [1:0]          r_count;

  logic                w_ar_hs;
  logic                w_rvalid;
  logic                w_pop;
  logic                w_head_last;
  logic [2:0]          w_occ;
  logic                w_issue;
  logic                w_last_issue;
  logic                w_err_slv;
  logic                w_err_dec;
  logic                w_beat_err;
  logic [1:0]          w_beat_resp;

  // Address bits above the 4 KB page are carried over so a burst never leaves its page.
  function automatic logic [AW-1:0] f_next_addr(input logic [AW-1:0] addr,
                                                 input logic [2:0]    size,
                                                 input logic [1:0]    burst,
                                                 input logic [7:0]    len);
    logic [AW-1:0] v_bytes;
    logic [AW-1:0] v_aligned;
    logic [AW-1:0] v_incr;
    logic [AW-1:0] v_wmask;
    logic [AW-1:0] v_nxt;
    v_bytes   = AW'(1) << size;
    v_aligned = addr & ~(v_bytes - AW'(1));
    v_incr    = v_aligned + v_bytes;
    v_wmask   = ((AW'(len) + AW'(1)) << size) - AW'(1);
    case (burst)
      2'b00:   v_nxt = addr;
      2'b10:   v_nxt = (addr & ~v_wmask) | (v_incr & v_wmask);
      default: v_nxt = v_incr;
    endcase
    return {addr[AW-1:12], v_nxt[11:0]};
  endfunction

  assign w_ar_hs      = s_axi.i_arvalid & r_arready;
  assign w_rvalid     = (r_count != 2'd0);
  assign w_pop        = w_rvalid & s_axi.i_rready;
  assign w_head_last  = r_buf_last[r_rd_ptr];
  assign w_occ        = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_issue      = (r_state == ST_BUSY) && (r_issued <= {1'b0, r_len}) && (w_occ < 3'd2);
  assign w_last_issue = w_issue && (r_issued == {1'b0, r_len});

  assign w_err_slv    = LP_ERR_EN && (r_size > 3'(DSZ));
  assign w_err_dec    = LP_ERR_EN && (r_addr >= AW'(MEM_BYTES));
  assign w_beat_err   = w_err_slv | w_err_dec;

  always_comb begin
    w_beat_resp = 2'b00;
    if (w_err_slv) begin
      w_beat_resp = 2'b10;
    end else if (w_err_dec) begin
      w_beat_resp = 2'b11;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_ar_hs)              w_state_nxt = ST_BUSY;
      ST_BUSY:  if (w_last_issue)         w_state_nxt = ST_DRAIN;
      ST_DRAIN: if (w_pop && w_head_last) w_state_nxt = ST_IDLE;
      default:                            w_state_nxt = ST_IDLE;
    endcase
    w_arready_nxt = (w_state_nxt == ST_IDLE);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= ST_IDLE;
      r_arready <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_arready <= w_arready_nxt;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_addr   <= '0;
      r_id     <= '0;
      r_len    <= '0;
      r_size   <= '0;
      r_burst  <= '0;
      r_issued <= '0;
    end else if (w_ar_hs) begin
      r_addr   <= s_axi.i_araddr;
      r_id     <= s_axi.i_arid;
      r_len    <= s_axi.i_arlen;
      r_size   <= s_axi.i_arsize;
      r_burst  <= (s_axi.i_arburst == 2'b11) ? 2'b01 : s_axi.i_arburst;
      r_issued <= '0;
    end else if (w_issue) begin
      r_addr   <= f_next_addr(r_addr, r_size, r_burst, r_len);
      r_issued <= r_issued + 9'd1;
    end
  end

  // Beat metadata travels alongside the SRAM read so it lands with its data.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_inflight <= 1'b0;
      r_if_last  <= 1'b0;
      r_if_err   <= 1'b0;
      r_if_resp  <= 2'b00;
    end else begin
      r_inflight <= w_issue;
      r_if_last  <= w_last_issue;
      r_if_err   <= w_beat_err;
      r_if_resp  <= w_beat_resp;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_buf_data <= '0;
      r_buf_resp <= '0;
      r_buf_last <= '0;
      r_wr_ptr   <= 1'b0;
      r_rd_ptr   <= 1'b0;
      r_count    <= 2'd0;
    end else begin
      if (r_inflight) begin
        r_buf_data[r_wr_ptr] <= r_if_err ? '0 : i_mem_rdata;
        r_buf_resp[r_wr_ptr] <= r_if_resp;
        r_buf_last[r_wr_ptr] <= r_if_last;
        r_wr_ptr             <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_count <= r_count + {1'b0, r_inflight} - {1'b0, w_pop};
    end
  end

  assign s_axi.o_arready = r_arready;
  assign s_axi.o_rvalid  = w_rvalid;
  assign s_axi.o_rdata   = w_rvalid ? r_buf_data[r_rd_ptr] : '0;
  assign s_axi.o_rresp   = w_rvalid ? r_buf_resp[r_rd_ptr] : 2'b00;
  assign s_axi.o_rlast   = w_rvalid & w_head_last;
  assign s_axi.o_rid     = r_id;

  assign o_mem_rd_en = w_issue & ~w_beat_err;
  assign o_mem_addr  = r_addr;
  assign o_busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_axi_rd_burst_ctrl.sv
// Directed self-checking bench for axi_rd_burst_ctrl: burst types, 4 KB bound, backpressure, mid-burst reset.
module tb_axi_rd_burst_ctrl;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int IDW = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           mem_rd_en;
  logic [AW-1:0]  mem_addr;
  logic [DW-1:0]  mem_rdata = '0;
  logic           busy;

  int checks = 0;
  int errors = 0;

  logic [31:0] expAddr [16];
  int          nExp;
  logic [31:0] gNextAddr  = '0;
  logic [3:0]  gNextId    = '0;
  logic [7:0]  gNextLen   = '0;
  logic [2:0]  gNextSize  = '0;
  logic [1:0]  gNextBurst = '0;
  bit          pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  always #5 clk = ~clk;

  axi_rd_burst_ctrl_if #(.AW(AW), .DW(DW), .IDW(IDW)) s_axi ();

  axi_rd_burst_ctrl #(.AW(AW), .DW(DW), .IDW(IDW), .MEM_BYTES(4096)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .s_axi       (s_axi),
    .o_mem_rd_en (mem_rd_en),
    .o_mem_addr  (mem_addr),
    .i_mem_rdata (mem_rdata),
    .o_busy      (busy)
  );

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return {16'hC0DE, a[15:2], 2'b00};
  endfunction

  // SRAM with one cycle of read latency
  always @(posedge clk) begin
    if (mem_rd_en) mem_rdata <= memWord(mem_addr);
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] addr, input logic [3:0] id,
                               input logic [7:0] len, input logic [2:0] size,
                               input logic [1:0] burst, input logic rready);
    s_axi.i_arvalid = v;
    s_axi.i_araddr  = addr;
    s_axi.i_arid    = id;
    s_axi.i_arlen   = len;
    s_axi.i_arsize  = size;
    s_axi.i_arburst = burst;
    s_axi.i_rready  = rready;
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_arready"}, s_axi.o_arready, 0);
    checkOutput({tag, "_rvalid"},  s_axi.o_rvalid,  0);
    checkOutput({tag, "_rlast"},   s_axi.o_rlast,   0);
    checkOutput({tag, "_rresp"},   s_axi.o_rresp,   0);
    checkOutput({tag, "_rid"},     s_axi.o_rid,     0);
    checkOutput({tag, "_rdata"},   s_axi.o_rdata,   0);
    checkOutput({tag, "_rd_en"},   mem_rd_en,       0);
    checkOutput({tag, "_mem_addr"}, mem_addr,       0);
    checkOutput({tag, "_busy"},    busy,            0);
  endtask

  // Cycle 1 is the first cycle after the AR handshake edge.
  task automatic runBurst(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                          input logic [1:0] burst, input logic [3:0] id, input bit usePattern,
                          input bit preAccepted, input bit holdNext);
    int   cyc = 0;
    int   waitCyc = 0;
    int   nIssued = 0;
    int   nBeats = 0;
    int   firstRd = -1;
    int   firstRv = -1;
    int   lastRd = -1;
    bit   done = 1'b0;
    bit   stalled = 1'b0;
    logic [31:0] heldData = '0;
    logic        heldLast = 1'b0;
    logic        rr;
    if (!preAccepted) begin
      @(negedge clk);
      applyStimulus(1'b1, addr, id, len, size, burst, 1'b0);
      #1;
      while (s_axi.o_arready !== 1'b1 && waitCyc < 20) begin
        @(negedge clk);
        #1;
        waitCyc++;
      end
      checkOutput("ar_accept", s_axi.o_arready, 1);
    end
    while (!done && cyc < 200) begin
      @(negedge clk);
      cyc++;
      rr = usePattern ? pat[cyc % 6] : 1'b1;
      applyStimulus(holdNext, gNextAddr, gNextId, gNextLen, gNextSize, gNextBurst, rr);
      #1;
      if (holdNext) checkOutput("ar_blocked", s_axi.o_arready, 0);
      if (stalled) begin
        checkOutput("stall_valid", s_axi.o_rvalid, 1);
        checkOutput("stall_data", s_axi.o_rdata, heldData);
        checkOutput("stall_last", s_axi.o_rlast, heldLast);
      end
      if (mem_rd_en) begin
        if (firstRd < 0) firstRd = cyc;
        lastRd = cyc;
        if (nIssued < nExp) checkOutput("mem_addr", mem_addr, expAddr[nIssued]);
        else checkOutput("extra_read", nIssued, nExp);
        nIssued++;
      end
      if (s_axi.o_rvalid && firstRv < 0) firstRv = cyc;
      if (s_axi.o_rvalid && rr) begin
        if (nBeats < nExp) checkOutput("rdata", s_axi.o_rdata, memWord(expAddr[nBeats]));
        else checkOutput("extra_beat", nBeats, nExp);
        checkOutput("rlast", s_axi.o_rlast, (nBeats == int'(len)));
        checkOutput("rid", s_axi.o_rid, id);
        checkOutput("rresp", s_axi.o_rresp, 0);
        nBeats++;
        if (s_axi.o_rlast) done = 1'b1;
      end
      checkOutput("outstanding_le2", (nIssued - nBeats) <= 2, 1);
      stalled  = s_axi.o_rvalid && !rr;
      heldData = s_axi.o_rdata;
      heldLast = s_axi.o_rlast;
    end
    checkOutput("burst_done", done, 1);
    checkOutput("beat_count", nBeats, int'(len) + 1);
    checkOutput("read_count", nIssued, int'(len) + 1);
    if (!usePattern) begin
      checkOutput("first_rd_cycle", firstRd, 1);
      checkOutput("first_rvalid_cycle", firstRv, 3);
      checkOutput("last_rd_cycle", lastRd, int'(len) + 1);
    end
    @(negedge clk);
    applyStimulus(holdNext, gNextAddr, gNextId, gNextLen, gNextSize, gNextBurst, 1'b1);
    #1;
    checkOutput("arready_after_last", s_axi.o_arready, 1);
    checkOutput("busy_after_last", busy, 0);
    checkOutput("rvalid_after_last", s_axi.o_rvalid, 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int beats;
    int cyc;
    applyStimulus(1'b0, '0, '0, '0, '0, '0, 1'b0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    checkResetValues("reset");
    rst_n = 1'b1;
    #1;
    checkOutput("arready_before_edge", s_axi.o_arready, 0);
    @(negedge clk);
    #1;
    checkOutput("arready_after_edge", s_axi.o_arready, 1);

    $display("[TB] INCR burst");
    expAddr[0] = 32'h100; expAddr[1] = 32'h104; expAddr[2] = 32'h108; expAddr[3] = 32'h10C; nExp = 4;
    runBurst(32'h100, 8'd3, 3'd2, 2'b01, 4'hA, 1'b0, 1'b0, 1'b0);

    $display("[TB] WRAP burst");
    expAddr[0] = 32'h108; expAddr[1] = 32'h10C; expAddr[2] = 32'h100; expAddr[3] = 32'h104; nExp = 4;
    runBurst(32'h108, 8'd3, 3'd2, 2'b10, 4'h2, 1'b0, 1'b0, 1'b0);

    $display("[TB] FIXED burst");
    expAddr[0] = 32'h20; expAddr[1] = 32'h20; expAddr[2] = 32'h20; nExp = 3;
    runBurst(32'h20, 8'd2, 3'd2, 2'b00, 4'h7, 1'b0, 1'b0, 1'b0);

    $display("[TB] INCR across 4 KB page");
    expAddr[0] = 32'h1FF8; expAddr[1] = 32'h1FFC; expAddr[2] = 32'h1000; expAddr[3] = 32'h1004; nExp = 4;
    runBurst(32'h1FF8, 8'd3, 3'd2, 2'b01, 4'h1, 1'b0, 1'b0, 1'b0);

    $display("[TB] reserved burst type behaves as INCR");
    expAddr[0] = 32'h80; expAddr[1] = 32'h84; nExp = 2;
    runBurst(32'h80, 8'd1, 3'd2, 2'b11, 4'hC, 1'b0, 1'b0, 1'b0);

    $display("[TB] backpressure with a second AR held pending");
    for (int i = 0; i < 8; i++) expAddr[i] = 32'h200 + 32'(4 * i);
    nExp = 8;
    gNextAddr = 32'h40; gNextId = 4'h9; gNextLen = 8'd0; gNextSize = 3'd2; gNextBurst = 2'b01;
    runBurst(32'h200, 8'd7, 3'd2, 2'b01, 4'h3, 1'b1, 1'b0, 1'b1);
    expAddr[0] = 32'h40; nExp = 1;
    runBurst(32'h40, 8'd0, 3'd2, 2'b01, 4'h9, 1'b0, 1'b1, 1'b0);

    $display("[TB] reset in the middle of a burst");
    @(negedge clk);
    applyStimulus(1'b1, 32'h300, 4'h5, 8'd7, 3'd2, 2'b01, 1'b1);
    #1;
    checkOutput("mid_ar_accept", s_axi.o_arready, 1);
    beats = 0;
    cyc = 0;
    while (beats < 2 && cyc < 20) begin
      @(negedge clk);
      applyStimulus(1'b0, '0, '0, '0, '0, '0, 1'b1);
      #1;
      if (s_axi.o_rvalid) beats++;
      cyc++;
    end
    checkOutput("mid_two_beats_seen", beats, 2);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkResetValues("mid_reset");
    @(negedge clk);
    #1;
    checkOutput("mid_reset_hold_rvalid", s_axi.o_rvalid, 0);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    checkOutput("post_reset_rvalid", s_axi.o_rvalid, 0);
    checkOutput("post_reset_arready", s_axi.o_arready, 1);
    expAddr[0] = 32'h44; nExp = 1;
    runBurst(32'h44, 8'd0, 3'd2, 2'b01, 4'h6, 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_rd_burst_ctrl.md
Name: axi_rd_burst_ctrl

Overview:
AXI4 read-channel slave controller for our AXI slave. It accepts one AR request at a time, walks the burst beat by beat using the axi_addr next-address generator (FIXED/INCR/WRAP, 4 KB-bounded), and issues single-word reads to a 1-cycle-latency SRAM port. Returned data goes through a 2-entry R buffer, so the block sustains one beat per cycle under RREADY backpressure.

Parameters:
AW, 32, address width
DW, 32, data width (bytes per beat = DW/8; DSZ = log2(DW/8))
IDW, 4, AXI ID width
MEM_BYTES, 4096, mapped memory size in bytes (used only with AXI_RD_ERR_EN)

Ports:
i_clk  in  1  clock
i_rst_n  in  1  asynchronous active-low reset
i_arvalid  in  1  AR valid
o_arready  out  1  AR ready
i_araddr  in  AW  burst start byte address
i_arid  in  IDW  transaction ID
i_arlen  in  8  beats minus 1
i_arsize  in  3  log2 bytes per beat
i_arburst  in  2  00 FIXED, 01 INCR, 10 WRAP
o_rvalid  out  1  R valid
i_rready  in  1  R ready
o_rdata  out  DW  read data
o_rid  out  IDW  = latched ARID
o_rresp  out  2  response
o_rlast  out  1  final beat
o_mem_rd_en  out  1  SRAM read strobe
o_mem_addr  out  AW  SRAM byte address (SRAM ignores low DSZ bits)
i_mem_rdata  in  DW  SRAM data, valid the cycle after o_mem_rd_en
o_busy  out  1  burst in progress

Behaviour:
- Reset (async assert, sync deassert): state IDLE, o_arready=0, o_rvalid=0, o_rlast=0, o_rresp=0, o_rid=0, o_rdata=0, o_mem_rd_en=0, o_mem_addr=0, o_busy=0. Buffer and counters cleared. o_arready rises on the first clock edge after deassertion.
- States: IDLE (o_arready=1) -> BUSY on AR handshake (arvalid&arready). BUSY -> DRAIN after the last SRAM read is issued. DRAIN -> IDLE on the R handshake of the last beat. o_arready is registered, so it is high again the cycle after the last R handshake. o_busy = state != IDLE.
- AR handshake latches addr, id, len, size and burst. Burst 2'b11 (reserved) is treated as INCR.
- Beat 0 address is ARADDR unmodified (unaligned allowed). Beat n+1 address = axi_addr(beat n address, size, burst, len). Bits [AW-1:12] never change within a burst.
- Issue rule: o_mem_rd_en=1 in BUSY when issued_cnt <= len and (buf_count + inflight - pop_this_cycle) < 2. inflight is 1 for the cycle after a read. issued_cnt is 9 bits.
- i_mem_rdata is written into the buffer on the edge ending the cycle after o_mem_rd_en. o_rvalid = buffer non-empty.
- Latency: AR handshake in cycle 0, rd_en in cycle 1, first o_rvalid in cycle 3. With i_rready held at 1, one beat per cycle follows.
- o_rdata/o_rresp/o_rlast are held stable while o_rvalid & !i_rready. Beat order is preserved. Full-width data is returned with no lane shifting.
- o_rlast = 1 on the head entry whose beat index equals len. len=0 gives a single beat with o_rlast=1.
- The buffer never overflows: the issue rule guarantees capacity. A write and a pop in the same cycle keep buf_count unchanged.
- i_arvalid in any state other than IDLE is ignored (arready low).
- Reset mid-burst: the burst is abandoned, the in-flight SRAM read is discarded, and no R beat is produced after reset.

Optional Feature:
AXI_RD_ERR_EN:
- Defined: a beat whose address >= MEM_BYTES, or a burst with ARSIZE > DSZ, returns o_rresp=2'b11 (DECERR) or 2'b10 (SLVERR) respectively, with o_rdata=0 and no SRAM read for that beat. The beat count and o_rlast are unchanged.
- Undefined: o_rresp is always 2'b00 and every beat reads the SRAM.

Test Plan:
- INCR: addr 0x100, len=3, size=2, rready=1 -> o_mem_addr 0x100,0x104,0x108,0x10C in consecutive cycles; rvalid from cycle 3; rlast on 4th beat; rid=ARID; arready high the cycle after the last beat.
- WRAP: addr 0x108, len=3, size=2 -> addresses 0x108,0x10C,0x100,0x104; rlast on 0x104 data.
- FIXED: addr 0x20, len=2 -> 0x20 three times; 3 beats; rlast on the third.
- 4 KB bound with INCR: addr 0x1FF8, len=3, size=2 -> 0x1FF8,0x1FFC,0x1000,0x1004.
- Backpressure: len=7, rready pattern 1,0,0,1,0,1... -> never more than 2 beats buffered or in flight; rdata stable while stalled; 8 beats in order; a second AR asserted mid-burst is not accepted until after the last beat.
- Reset mid-burst: assert i_rst_n=0 after beat 2 of len=7 -> all outputs at reset values immediately; after release, a new len=0 burst returns exactly one beat with rlast=1.
